// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: state encoding, vector addresses and bus widths,
// reused by decode and the memory arbiter.
package fetch_pkg;

  typedef enum logic [1:0] {
    VEC_RST = 2'd0,
    RUN     = 2'd1,
    VEC_INT = 2'd2,
    HALT    = 2'd3
  } fetch_state_e;

  localparam int         FETCH_ADDR_W  = 8;
  localparam int         FETCH_DATA_W  = 8;
  localparam logic [7:0] FETCH_RST_VEC = 8'h00;
  localparam logic [7:0] FETCH_INT_VEC = 8'h01;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect/hazard controls from later
// stages, and the IF/ID register plus interrupt handshake toward decode.
interface fetch_unit_if import fetch_pkg::*; #(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              hlt;
  logic              interrupt;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc_next;
  logic              if_valid;
  logic              int_ack;
  logic [ADDR_W-1:0] int_ret_pc;
  logic              halted;

  modport master (
    output imem_addr, pc, if_instr, if_pc_next, if_valid, int_ack, int_ret_pc, halted,
    input  imem_data, stall, redirect_valid, redirect_pc, hlt, interrupt
  );

  modport slave (
    input  imem_addr, pc, if_instr, if_pc_next, if_valid, int_ack, int_ret_pc, halted,
    output imem_data, stall, redirect_valid, redirect_pc, hlt, interrupt
  );
endinterface

// File: rtl/fetch_unit_irq_latch.sv
// Interrupt rising-edge detector with a sticky pending flag; an edge coinciding
// with a clear wins so no request is lost.
module irq_latch (
  input  logic clk,
  input  logic rst,
  input  logic interrupt,
  input  logic clear,
  output logic pending
);
  logic irq_prev;
  logic irq_edge;

  assign irq_edge = interrupt & ~irq_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      irq_prev <= interrupt;
      pending  <= irq_edge | (pending & ~clear);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, reset/interrupt vectoring, HLT stop and the IF/ID
// register feeding decode.
module fetch_unit import fetch_pkg::*; #(
  parameter int                ADDR_W  = FETCH_ADDR_W,
  parameter int                DATA_W  = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RST_VEC = FETCH_RST_VEC,
  parameter logic [ADDR_W-1:0] INT_VEC = FETCH_INT_VEC
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc_p0, pc_nxt, pc_inc;
  logic [ADDR_W-1:0] ret_pc_q;
  logic [DATA_W-1:0] instr_p1, instr_nxt;
  logic [ADDR_W-1:0] pc_next_p1, pc_next_nxt;
  logic              vld_p1, vld_nxt;
  logic              halted_q, halted_nxt;
  logic              int_take;
  logic              irq_pending;

  irq_latch u_irq_latch (
    .clk       (clk),
    .rst       (rst),
    .interrupt (bus.interrupt),
    .clear     (int_take),
    .pending   (irq_pending)
  );

  assign pc_inc = pc_p0 + ADDR_W'(1);

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_p0;
    instr_nxt     = instr_p1;
    pc_next_nxt   = pc_next_p1;
    vld_nxt       = vld_p1;
    halted_nxt    = halted_q;
    int_take      = 1'b0;
    bus.imem_addr = pc_p0;
    case (state)
      VEC_RST: begin
        bus.imem_addr = RST_VEC;
        pc_nxt        = ADDR_W'(bus.imem_data);
        state_nxt     = RUN;
        vld_nxt       = 1'b0;
      end
      VEC_INT: begin
        bus.imem_addr = INT_VEC;
        pc_nxt        = ADDR_W'(bus.imem_data);
        state_nxt     = RUN;
        vld_nxt       = 1'b0;
      end
      RUN: begin
        // Priority: redirect beats HLT beats interrupt take beats stall.
        if (bus.redirect_valid) begin
          pc_nxt  = bus.redirect_pc;
          vld_nxt = 1'b0;
        end else if (bus.hlt) begin
          state_nxt  = HALT;
          halted_nxt = 1'b1;
          vld_nxt    = 1'b0;
        end else if (irq_pending && !bus.stall) begin
          int_take  = 1'b1;
          state_nxt = VEC_INT;
          vld_nxt   = 1'b0;
        end else if (!bus.stall) begin
          instr_nxt   = bus.imem_data;
          pc_next_nxt = pc_inc;
          vld_nxt     = 1'b1;
          pc_nxt      = pc_inc;
        end
      end
      HALT: halted_nxt = 1'b1;
    endcase
  end

  // Stage p0 -> p1: PC update and IF/ID capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= VEC_RST;
      pc_p0      <= '0;
      instr_p1   <= '0;
      pc_next_p1 <= '0;
      vld_p1     <= 1'b0;
      halted_q   <= 1'b0;
      ret_pc_q   <= '0;
    end else begin
      state      <= state_nxt;
      pc_p0      <= pc_nxt;
      instr_p1   <= instr_nxt;
      pc_next_p1 <= pc_next_nxt;
      vld_p1     <= vld_nxt;
      halted_q   <= halted_nxt;
      if (int_take) ret_pc_q <= pc_p0;
    end
  end

  assign bus.pc         = pc_p0;
  assign bus.if_instr   = instr_p1;
  assign bus.if_pc_next = pc_next_p1;
  assign bus.if_valid   = vld_p1;
  assign bus.int_ack    = int_take;
  assign bus.int_ret_pc = int_take ? pc_p0 : ret_pc_q;
  assign bus.halted     = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetched bytes are predicted into a scoreboard
// queue when the address is presented and checked when IF/ID is loaded.
module tb_fetch_unit;
  import fetch_pkg::*;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] pc_next;
  } fetch_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem [256];
  fetch_t     sb [$];
  int         n_assert = 0;
  int         n_fail   = 0;

  fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.imem_data = mem[bus.imem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [7:0] addr);
    logic [7:0] nxt;
    nxt = addr + 8'd1;
    sb.push_back({mem[addr], nxt});
  endtask

  task automatic pop_check(input string tag);
    fetch_t e;
    chk({tag, "_vld"}, bus.if_valid, 1);
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_instr"}, bus.if_instr, e.instr);
      chk({tag, "_pcnext"}, bus.if_pc_next, e.pc_next);
    end
  endtask

  task automatic fetch_step(input string tag, input logic [7:0] exp_pc_after);
    push_fetch(bus.pc);
    tick();
    pop_check(tag);
    chk({tag, "_pc"}, bus.pc, exp_pc_after);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h00] = 8'h10;
    mem[8'h01] = 8'h80;
    mem[8'h10] = 8'hA5;

    rst                = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    bus.hlt            = 1'b0;
    bus.interrupt      = 1'b0;

    // Reset held for three edges
    repeat (3) tick();
    chk("rst_pc", bus.pc, 0);
    chk("rst_vld", bus.if_valid, 0);
    chk("rst_instr", bus.if_instr, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_ack", bus.int_ack, 0);
    chk("rst_addr", bus.imem_addr, 8'h00);

    rst = 1'b1;
    tick();
    chk("vec_pc", bus.pc, 8'h10);
    chk("vec_vld", bus.if_valid, 0);
    chk("vec_addr", bus.imem_addr, 8'h10);
    fetch_step("f10", 8'h11);
    fetch_step("f11", 8'h12);

    // Stall two cycles at 0x12
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_pc", bus.pc, 8'h12);
      chk("stall_vld", bus.if_valid, 1);
      chk("stall_instr", bus.if_instr, mem[8'h11]);
    end
    bus.stall = 1'b0;
    fetch_step("f12", 8'h13);
    fetch_step("f13", 8'h14);

    // Interrupt edge raised while fetching 0x14; taken at pc 0x15
    bus.interrupt = 1'b1;
    fetch_step("f14", 8'h15);
    bus.interrupt = 1'b0;
    #1;
    chk("irq_ack", bus.int_ack, 1);
    chk("irq_ret", bus.int_ret_pc, 8'h15);
    tick();
    chk("irq_b1_vld", bus.if_valid, 0);
    chk("irq_b1_ack", bus.int_ack, 0);
    chk("irq_b1_addr", bus.imem_addr, 8'h01);
    bus.interrupt = 1'b1;
    tick();
    chk("irq_b2_vld", bus.if_valid, 0);
    chk("irq_isr_pc", bus.pc, 8'h80);
    chk("irq2_ack", bus.int_ack, 1);
    chk("irq2_ret", bus.int_ret_pc, 8'h80);
    bus.interrupt = 1'b0;
    tick();
    chk("irq2_vec_addr", bus.imem_addr, 8'h01);
    tick();
    chk("irq2_pc", bus.pc, 8'h80);
    chk("irq2_cleared", bus.int_ack, 0);
    fetch_step("f80", 8'h81);

    // Redirect beats a simultaneous stall
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h40;
    bus.stall          = 1'b1;
    tick();
    chk("redir_pc", bus.pc, 8'h40);
    chk("redir_vld", bus.if_valid, 0);
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    fetch_step("f40", 8'h41);

    // PC wrap from 0xFF
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hFF;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wrap_redir_pc", bus.pc, 8'hFF);
    fetch_step("fFF", 8'h00);

    // HLT at 0x20, interrupts ignored, reset exits
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h20;
    tick();
    bus.redirect_valid = 1'b0;
    bus.hlt            = 1'b1;
    tick();
    bus.hlt = 1'b0;
    chk("hlt_halted", bus.halted, 1);
    chk("hlt_pc", bus.pc, 8'h20);
    chk("hlt_vld", bus.if_valid, 0);
    bus.interrupt = 1'b1;
    tick();
    bus.interrupt = 1'b0;
    tick();
    tick();
    chk("hlt_irq_ack", bus.int_ack, 0);
    chk("hlt_irq_pc", bus.pc, 8'h20);
    chk("hlt_irq_addr", bus.imem_addr, 8'h20);
    chk("hlt_still", bus.halted, 1);
    rst = 1'b0;
    tick();
    chk("hrst_halted", bus.halted, 0);
    chk("hrst_pc", bus.pc, 0);
    chk("hrst_addr", bus.imem_addr, 8'h00);
    rst = 1'b1;
    tick();
    chk("hrst_vec_pc", bus.pc, 8'h10);
    chk("hrst_ack", bus.int_ack, 0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 8-bit pipelined processor. It owns the program counter and loads it from the reset vector M[0] after reset. It vectors through M[1] on an external interrupt and stops fetching on HLT. Each cycle it drives the instruction-memory address and registers the returned byte into the IF/ID register consumed by decode. Redirects come from later stages.

## Interface
- ADDR_W, 8, PC / memory address width
- DATA_W, 8, instruction byte width
- RST_VEC, 8'h00, address holding the reset start PC
- INT_VEC, 8'h01, address holding the interrupt service PC
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- imem_addr  out  ADDR_W  instruction-memory read address (combinational from state/pc)
- imem_data  in  DATA_W  memory read data, valid same cycle (asynchronous read)
- stall  in  1  load-use/structural hazard: hold PC and IF/ID
- redirect_valid  in  1  branch/jump/CALL/RET/RTI taken
- redirect_pc  in  ADDR_W  target for redirect
- hlt  in  1  HLT decoded, stop fetching
- interrupt  in  1  external interrupt request, level input, rising edge significant
- pc  out  ADDR_W  current program counter
- if_instr  out  DATA_W  IF/ID instruction byte
- if_pc_next  out  ADDR_W  address after if_instr (CALL return value)
- if_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- int_ack  out  1  one-cycle pulse when interrupt is taken
- int_ret_pc  out  ADDR_W  PC to push for RTI, valid while int_ack=1
- halted  out  1  fetch stopped by HLT (drives HLT_Flag)

## Operation
- States: VEC_RST, RUN, VEC_INT, HALT.
- Reset (rst=0 at an edge):
  - state<=VEC_RST, pc<=0, if_instr<=0, if_pc_next<=0, if_valid<=0.
  - int_ack=0, int_ret_pc<=0, halted<=0, irq pending<=0, irq edge history<=0.
- VEC_RST:
  - imem_addr=RST_VEC.
  - Next edge: pc<=imem_data, state<=RUN, if_valid<=0.
- RUN: imem_addr=pc. Per edge, first matching rule wins:
  1. redirect_valid: pc<=redirect_pc, if_valid<=0. Applies even when stall=1.
  2. hlt: state<=HALT, halted<=1, if_valid<=0, pc held.
  3. Pending irq and stall=0:
     - int_ack=1, int_ret_pc=pc; clear pending.
     - state<=VEC_INT, if_valid<=0.
  4. stall: pc, if_instr, if_pc_next, if_valid all held.
  5. Normal fetch:
     - if_instr<=imem_data, if_pc_next<=pc+1, if_valid<=1.
     - pc<=pc+1, modulo 2^ADDR_W (0xFF wraps to 0x00).
- VEC_INT:
  - imem_addr=INT_VEC.
  - Next edge: pc<=imem_data, state<=RUN, if_valid<=0.
  - redirect_valid and hlt are ignored in this state.
- HALT:
  - imem_addr=pc; outputs frozen, halted=1.
  - Only reset leaves HALT. Interrupt edges set pending but are never taken.
- Interrupt capture:
  - A rising edge (interrupt=1, previous sample 0) sets pending.
  - Pending stays set across VEC_RST, VEC_INT, stall and redirect until taken.
  - A second edge while pending is already set is merged into it.
  - If an edge arrives in the same cycle pending is cleared by a take, pending stays set.

## Timing
- Reset vector latency: first edge with rst=1 loads pc from M[RST_VEC]; the fetch of that address occurs on the following edge.
- Normal throughput: one instruction per cycle. if_instr appears one edge after imem_addr presents its address.
- Redirect: one bubble (if_valid=0), target fetched on the next edge.
- Interrupt: take edge plus VEC_INT edge, giving 2 bubbles before the ISR's first fetch.
- int_ack is combinational from state/pending/stall/redirect/hlt in RUN, high for exactly one cycle per take.
- imem_addr must be glitch-free relative to state; it is a pure mux of state and pc.

## Structure
- Shared package `fetch_pkg`:
  - state encoding (2-bit enum: VEC_RST, RUN, VEC_INT, HALT)
  - RST_VEC/INT_VEC defaults and ADDR_W/DATA_W constants, reused by decode and the memory arbiter
- One sub-module `irq_latch`: interrupt edge detector plus pending flag, with inputs clk, rst, interrupt, clear, and output pending.
- Top-level `fetch_unit` holds the FSM, PC and IF/ID registers.

## Test plan
- Reset: M[0]=0x10, M[0x10]=0xA5, hold rst=0 3 cycles then release → pc=0x10 one cycle after release, pc=0x11 and if_instr=0xA5 with if_valid=1 the cycle after.
- Stall: stall=1 for 2 cycles at pc=0x12 → pc, if_instr and if_valid unchanged both cycles; fetch resumes at 0x12 after release.
- Redirect with stall: redirect_valid=1, redirect_pc=0x40, stall=1 simultaneously → pc=0x40, if_valid=0 next cycle; M[0x40] fetched the cycle after.
- Interrupt: M[1]=0x80, pulse interrupt at pc=0x15 → int_ack=1 with int_ret_pc=0x15, 2 bubbles, pc=0x80. A second edge during VEC_INT is taken right after returning to RUN.
- HLT: hlt=1 at pc=0x20 → halted=1, pc stays 0x20, if_valid=0. Interrupt edges are ignored. rst=0 for one edge → state VEC_RST, halted=0.
- Wrap: redirect to 0xFF, then normal fetch → pc=0x00 with if_pc_next=0x00 for the 0xFF instruction.
